// File: rtl/sqrt_rr_scheduler.sv
// Round-robin arbiter in front of one iterative sqrt unit: grant, start, watchdog, release, respond.
// req_ready is combinational in IDLE; sq_start rises 2 cycles after grant; holds RESP until owner's resp_ready.
module sqrt_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [31:0]          sq_in,
  output logic                 sq_start,
  input  logic [31:0]          sq_out,
  input  logic                 sq_done,
  input  logic                 sq_avail,
  output logic                 busy
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RELEASE, RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [31:0]     sq_in_q, sq_in_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic            sq_start_q, sq_start_d;
  logic [PW-1:0]   grant_idx;
  logic            grant_found;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // First valid requester at or after rr_ptr, modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[wrap_add(rr_ptr_q, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    tmo_cnt_d   = tmo_cnt_q;
    sq_in_d     = sq_in_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    sq_start_d  = sq_start_q;
    req_ready   = '0;
    resp_valid  = '0;
    unique case (state_q)
      IDLE: begin
        // Gated by rstn so no operand is handed over while reset is asserted.
        if (!rstn && sq_avail && grant_found) begin
          req_ready[grant_idx] = 1'b1;
          sq_in_d  = req_data[32*grant_idx +: 32];
          owner_d  = grant_idx;
          rr_ptr_d = wrap_add(grant_idx, 1);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        sq_start_d = 1'b1;
        tmo_cnt_d  = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (sq_done) begin
          resp_data_d = sq_out;
          resp_err_d  = 1'b0;
          sq_start_d  = 1'b0;
          state_d     = RELEASE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          sq_start_d  = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        if (!sq_done && sq_avail) state_d = RESP;
      end
      RESP: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      tmo_cnt_q   <= '0;
      sq_in_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      sq_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      tmo_cnt_q   <= tmo_cnt_d;
      sq_in_q     <= sq_in_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      sq_start_q  <= sq_start_d;
    end
  end

  assign sq_in     = sq_in_q;
  assign sq_start  = sq_start_q;
  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Directed + randomized bench for sqrt_rr_scheduler with a sqrt stub and a round-robin reference model.
module tb_sqrt_rr_scheduler;
  localparam int NREQ = 4;
  localparam int TMO  = 64;

  logic                clk = 1'b0;
  logic                rstn;
  logic [NREQ-1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [32*NREQ-1:0]  req_data;
  logic [31:0]         resp_data, sq_in, sq_out;
  logic                resp_err, sq_start, sq_done, sq_avail, busy;

  logic [31:0] rd [NREQ];
  int          errors = 0;
  int          checks = 0;
  int          exp_ptr = 0;
  int          dly = 13;
  bit          stub_on = 1'b1;
  int          scnt = 0;
  logic [31:0] lastd;

  sqrt_rr_scheduler #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .resp_ready(resp_ready), .sq_in(sq_in), .sq_start(sq_start),
    .sq_out(sq_out), .sq_done(sq_done), .sq_avail(sq_avail), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = rd[i];

  // Stub: DONE appears once START has been high for dly sampled edges, result = operand + 1.
  always @(posedge clk) scnt <= sq_start ? scnt + 1 : 0;
  assign sq_done = stub_on && sq_start && (scnt >= dly);
  assign sq_out  = sq_in + 32'd1;

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic model_err();
    return !stub_on || (dly >= TMO);
  endfunction

  function automatic logic [31:0] model_res();
    return model_err() ? 32'd0 : lastd + 32'd1;
  endfunction

  task automatic serve(output int g);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 300) begin cyc(); n++; end
    g = model_grant(req_valid, exp_ptr);
    chk("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    if (g < 0) g = 0;
    exp_ptr = (g + 1) % NREQ;
    lastd = rd[g];
  endtask

  task automatic get_resp(input int g, input logic [31:0] ed, input logic ee);
    int n = 0;
    #1;
    while (resp_valid == '0 && n < 300) begin cyc(); n++; end
    chk("resp_valid", 32'(resp_valid), 32'd1 << g);
    chk("resp_data", resp_data, ed);
    chk("resp_err", 32'(resp_err), 32'(ee));
    chk("busy_resp", 32'(busy), 32'd1);
    resp_ready = '0;
    resp_ready[g] = 1'b1;
    cyc();
    resp_ready = '0;
    chk("idle_after_resp", 32'(busy), 32'd0);
  endtask

  initial begin
    int g, r, n;
    int dlys [6];
    rstn = 1'b1; req_valid = '0; resp_ready = '0; sq_avail = 1'b1;
    for (int i = 0; i < NREQ; i++) rd[i] = '0;
    cyc(); cyc();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_sq_start", 32'(sq_start), 0);
    chk("rst_busy", 32'(busy), 0);
    rstn = 1'b0;
    cyc();

    // Single request: immediate ready, start two cycles later.
    rd[0] = 32'h100; req_valid = 4'b0001;
    serve(g);
    cyc(); req_valid = '0; #1;
    chk("ready_once", 32'(req_ready), 0);
    chk("start_not_yet", 32'(sq_start), 0);
    cyc();
    chk("start_rise", 32'(sq_start), 1);
    chk("sq_in", sq_in, 32'h100);
    get_resp(g, 32'h101, 1'b0);

    // Fairness with all requesters continuously valid.
    for (int i = 0; i < NREQ; i++) rd[i] = $urandom;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) chk("regrant_next_cycle", 32'(req_ready != '0), 1);
      serve(g);
      cyc();
      rd[g] = $urandom;
      get_resp(g, model_res(), model_err());
    end
    req_valid = '0;

    // Watchdog: DONE never comes, then release gated by AVAILABLE.
    stub_on = 1'b0;
    r = $urandom_range(0, NREQ - 1);
    rd[r] = $urandom; req_valid = '0; req_valid[r] = 1'b1;
    serve(g);
    cyc(); req_valid = '0; cyc();
    n = 0;
    while (sq_start && n < 200) begin n++; cyc(); end
    chk("wait_cycles", n, TMO);
    sq_avail = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("release_hold", 32'(resp_valid), 0);
    end
    sq_avail = 1'b1;
    get_resp(g, model_res(), model_err());
    stub_on = 1'b1;
    sq_avail = 1'b0; req_valid = 4'b0110; rd[1] = $urandom; rd[2] = $urandom;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("no_grant_unavail", 32'(req_ready), 0);
      cyc();
    end
    sq_avail = 1'b1;
    serve(g);
    cyc(); req_valid[g] = 1'b0;
    get_resp(g, model_res(), model_err());

    // Owner stalls its response; nothing else may be granted.
    rd[3] = $urandom; req_valid[3] = 1'b1;
    serve(g);
    cyc(); req_valid = '1;
    n = 0;
    #1;
    while (resp_valid == '0 && n < 300) begin cyc(); n++; end
    for (int k = 0; k < 20; k++) begin
      resp_ready = ~(4'b0001 << g);
      #1;
      chk("stall_valid", 32'(resp_valid), 32'd1 << g);
      chk("stall_data", resp_data, model_res());
      chk("stall_no_grant", 32'(req_ready), 0);
      cyc();
    end
    req_valid = '0; resp_ready = '0;
    get_resp(g, model_res(), model_err());

    // DONE near the watchdog boundary and random latencies.
    dlys[0] = TMO - 1; dlys[1] = TMO;
    for (int k = 2; k < 6; k++) dlys[k] = $urandom_range(0, 80);
    for (int k = 0; k < 6; k++) begin
      dly = dlys[k];
      r = $urandom_range(0, NREQ - 1);
      rd[r] = $urandom; req_valid = '0; req_valid[r] = 1'b1;
      serve(g);
      cyc(); req_valid = '0;
      get_resp(g, model_res(), model_err());
    end
    dly = 13;

    // Reset in the middle of WAIT.
    for (int i = 0; i < NREQ; i++) rd[i] = $urandom;
    req_valid = '1;
    serve(g);
    cyc(); cyc(); cyc();
    chk("pre_rst_start", 32'(sq_start), 1);
    rstn = 1'b1;
    #1;
    chk("mid_rst_start", 32'(sq_start), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_sq_in", sq_in, 0);
    chk("mid_rst_data", resp_data, 0);
    chk("mid_rst_err", 32'(resp_err), 0);
    cyc();
    rstn = 1'b0;
    exp_ptr = 0;
    serve(g);
    cyc(); req_valid = '0;
    get_resp(g, model_res(), model_err());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
